lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit between the core's memory pipeline stage and the data port of the dual-port RAM.
- Accepts one load/store at a time and checks alignment.
- Drives a req/addr_ok/data_ok SRAM-style bus with word address, byte strobes and lane-shifted write data.
- Returns sign- or zero-extended load data, or a misalignment flag, to the writeback stage.

Parameters:
AW, 32, byte-address width of pipeline and bus address ports
DW, 32, bus data width; only 32 supported (elaboration error otherwise)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  pipeline request valid
req_ready  output  1  LSU can accept request (state IDLE)
req_write  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
req_unsigned  input  1  load zero-extends when 1
req_addr  input  AW  byte address
req_wdata  input  32  store data, LSB-justified
req_rd  input  5  destination register tag, echoed on response
flush  input  1  cancel pending request, suppress its response
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data (0 for stores/errors)
rsp_rd  output  5  echoed tag
rsp_misaligned  output  1  request rejected for alignment
bus_req  output  1  bus request
bus_write  output  1  bus write
bus_wstrb  output  4  byte enables
bus_addr  output  AW  word address = {2'b0, addr[AW-1:2]}
bus_wdata  output  32  lane-aligned write data
bus_addr_ok  input  1  request accepted this cycle
bus_data_ok  input  1  response/completion this cycle
bus_rdata  input  32  read word

Behaviour:
- Reset (async, rst=1): state IDLE. req_ready=1. rsp_valid=0, rsp_rdata=0, rsp_rd=0, rsp_misaligned=0. bus_req=0. All registered request fields=0.
- States:
  - IDLE: req_ready=1. On req_valid & ~flush, register addr/size/write/unsigned/wdata/rd.
    - Aligned -> ADDR.
    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=3) -> ERR.
  - ADDR: bus_req=1 with registered fields stable until bus_addr_ok. On addr_ok -> DATA.
  - DATA: bus_req=0. Wait for bus_data_ok -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE.
    - Loads: rsp_rdata = bus_rdata captured at data_ok, then extended.
    - Stores: rsp_rdata = 0.
  - ERR: rsp_valid=1, rsp_misaligned=1, rsp_rdata=0 for one cycle, no bus activity -> IDLE.
- Latency with a zero-wait RAM (addr_ok tied 1, data_ok one cycle after):
  - Accept at T, bus_req at T+1, data_ok at T+2, rsp_valid at T+3.
  - Next request can be accepted at T+4.
- Strobe generation:
  - byte: wstrb = 1<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
  - Loads: wstrb = 0.
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load extraction:
  - byte lane = rdata[8*addr[1:0]+:8].
  - half = rdata[16*addr[1]+:16].
  - Sign-extend from bit 7/15 unless req_unsigned.
- flush:
  - In IDLE: blocks acceptance.
  - In ADDR before addr_ok: drop bus_req next cycle, -> IDLE, no response.
  - In ADDR coincident with addr_ok, or in DATA: bus transaction is committed. Go to/stay in DATA, wait for data_ok, then -> IDLE with no rsp_valid (use a drop flag).
  - In RESP/ERR: suppresses rsp_valid.
- bus_data_ok outside DATA is ignored. rst mid-transaction returns to IDLE immediately; no response.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum logic[1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD} lsu_size_e
  - typedef enum {IDLE, ADDR, DATA, RESP, ERR} lsu_state_e
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_align (combinational): generates wstrb/wdata from size/addr/wdata, and extended rdata from size/unsigned/addr/bus_rdata. Reused by verification model.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF, addr_ok=1 -> bus_addr=0x4, wstrb=4'hF, bus_wdata=0xDEADBEEF at T+1; rsp_valid at T+3, rsp_rdata=0.
- sb addr=0x13 wdata=0x000000A5 -> wstrb=4'b1000, bus_wdata=0xA5A5A5A5.
- lb addr=0x21 with bus_rdata=0x1234_80FF -> rsp_rdata=0xFFFFFF80. lbu same -> 0x00000080. lhu addr=0x22 -> 0x00001234.
- lw addr=0x6 -> no bus_req; rsp_valid next cycle, rsp_misaligned=1, rsp_rd echoed. sh addr=0x1 -> same.
- Backpressure: addr_ok held 0 for 3 cycles -> bus_req and all bus fields stable, req_ready=0; then addr_ok=1 -> normal completion.
- flush in ADDR (addr_ok=0) -> bus_req drops, no rsp. flush in DATA -> no rsp after data_ok, req_ready returns next cycle. rst asserted in DATA -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD} lsu_size_e;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, ERR} lsu_state_e;

  // Reserved size is always rejected, like a misaligned access.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = addr_lo[0];
      SIZE_W:  is_misaligned = |addr_lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data replication and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        write,
  input  logic        load_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wstrb      = '0;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (size)
      SIZE_B: begin
        wstrb      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = load_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      SIZE_H: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = load_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      SIZE_W: begin
        wstrb = 4'b1111;
      end
      default: begin
        wstrb = '0;
      end
    endcase
    if (!write) wstrb = '0;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access on a req/addr_ok/data_ok SRAM-style bus.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  input  logic          flush,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic [4:0]    rsp_rd,
  output logic          rsp_misaligned,
  output logic          bus_req,
  output logic          bus_write,
  output logic [3:0]    bus_wstrb,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [31:0]   bus_rdata
);

  if (DW != 32) begin : g_dw_check
    $error("lsu: only DW=32 is supported");
  end

  lsu_state_e    state, state_nxt;
  logic [AW-1:0] r_addr;
  lsu_size_e     r_size;
  logic          r_write;
  logic          r_unsigned;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic [31:0]   r_rdata;
  logic          drop, drop_nxt;
  logic          accept;

  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata;
  logic [31:0]   al_rdata;

  assign accept = (state == IDLE) && req_valid && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drop       <= 1'b0;
      r_addr     <= '0;
      r_size     <= SIZE_B;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_rdata    <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (accept) begin
        r_addr     <= req_addr;
        r_size     <= lsu_size_e'(req_size);
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
        r_rd       <= req_rd;
      end
      if (state == DATA && bus_data_ok) r_rdata <= bus_rdata;
    end
  end

  // Once addr_ok has been seen the bus owes a data_ok, so a flush from then on
  // is remembered in drop and the response is discarded when data_ok arrives.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (accept)
          state_nxt = is_misaligned(lsu_size_e'(req_size), req_addr[1:0]) ? ERR : ADDR;
      end
      ADDR: begin
        if (bus_addr_ok) begin
          state_nxt = DATA;
          drop_nxt  = flush;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        drop_nxt = drop || flush;
        if (bus_data_ok) begin
          state_nxt = (drop || flush) ? IDLE : RESP;
          drop_nxt  = 1'b0;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lsu_align u_align (
    .size          (r_size),
    .write         (r_write),
    .load_unsigned (r_unsigned),
    .addr_lo       (r_addr[1:0]),
    .wdata         (r_wdata),
    .rdata         (r_rdata),
    .wstrb         (al_wstrb),
    .wdata_lane    (al_wdata),
    .rdata_ext     (al_rdata)
  );

  assign req_ready = (state == IDLE);

  assign bus_req   = (state == ADDR);
  assign bus_write = bus_req && r_write;
  assign bus_wstrb = bus_req ? al_wstrb : '0;
  assign bus_addr  = bus_req ? {2'b00, r_addr[AW-1:2]} : '0;
  assign bus_wdata = (bus_req && r_write) ? al_wdata : '0;

  assign rsp_valid      = (state == RESP || state == ERR) && !flush;
  assign rsp_misaligned = (state == ERR) && !flush;
  assign rsp_rdata      = (state == RESP && !flush && !r_write) ? al_rdata : '0;
  assign rsp_rd         = r_rd;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table plus hand-written flush/backpressure/reset sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_misaligned;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        bus_req, bus_write, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_misaligned(rsp_misaligned),
    .bus_req(bus_req), .bus_write(bus_write), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] bus_rdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
  } rsp_t;

  rsp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rd=%0d expected none at %0t", rsp_rd, $time);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_rd", {27'h0, rsp_rd}, {27'h0, e.rd});
        chk("rsp_misaligned", {31'h0, rsp_misaligned}, {31'h0, e.mis});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v);
    rsp_t e;
    wait_ready();
    drive_req(v.write, v.size, v.uns, v.addr, v.wdata, v.rd);
    e.rdata = v.exp_rdata; e.rd = v.rd; e.mis = v.exp_mis;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (v.exp_mis) begin
      chk("mis_no_bus_req", {31'h0, bus_req}, 32'h0);
      chk("mis_rsp_next_cycle", {31'h0, rsp_valid}, 32'h1);
      @(posedge clk); #1;
    end else begin
      chk("bus_req", {31'h0, bus_req}, 32'h1);
      chk("bus_addr", bus_addr, v.addr >> 2);
      chk("bus_write", {31'h0, bus_write}, {31'h0, v.write});
      chk("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, v.exp_wstrb});
      if (v.write) chk("bus_wdata", bus_wdata, v.exp_wdata);
      bus_addr_ok = 1'b1;
      @(posedge clk); #1;
      bus_addr_ok = 1'b0;
      @(negedge clk);
      chk("bus_req_drop", {31'h0, bus_req}, 32'h0);
      bus_data_ok = 1'b1;
      bus_rdata = v.bus_rdata;
      @(posedge clk); #1;
      bus_data_ok = 1'b0;
      bus_rdata = $urandom;
      @(negedge clk);
      chk("rsp_latency", {31'h0, rsp_valid}, 32'h1);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[13];

  initial begin
    //           wr    sz     un    addr          wdata         rd     bus_rdata     strb     exp_wdata     exp_rdata     mis
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1,  32'h0,        4'hF,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 5'd2,  32'h0,        4'h8,   32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0,        5'd3,  32'h123480FF, 4'h0,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        5'd4,  32'h123480FF, 4'h0,   32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        5'd5,  32'h123480FF, 4'h0,   32'h0,        32'h00001234, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0,        5'd6,  32'h00009ABC, 4'h0,   32'h0,        32'hFFFF9ABC, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h8,  32'h0,        5'd7,  32'hCAFEF00D, 4'h0,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h2,  32'h1234BEEF, 5'd8,  32'h0,        4'hC,   32'hBEEFBEEF, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h0,  32'h00000077, 5'd9,  32'h0,        4'h1,   32'h77777777, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h6,  32'h0,        5'd10, 32'h0,        4'h0,   32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h1,  32'h5555,     5'd11, 32'h0,        4'h0,   32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h0,  32'h0,        5'd12, 32'h0,        4'h0,   32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h3,  32'h0,        5'd13, 32'h7F000000, 4'h0,   32'h0,        32'h0000007F, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    #3;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_rsp_rd", {27'h0, rsp_rd}, 32'h0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // flush in IDLE blocks acceptance
    drive_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 5'd20);
    flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_ready", {31'h0, req_ready}, 32'h1);
    chk("idle_flush_no_req", {31'h0, bus_req}, 32'h0);

    // stray data_ok while idle is ignored
    bus_data_ok = 1'b1;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("stray_data_ok", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;

    // backpressure: addr_ok low for 3 cycles
    begin
      rsp_t e;
      drive_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, 5'd21);
      e.rdata = 32'h0; e.rd = 5'd21; e.mis = 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("bp_bus_req", {31'h0, bus_req}, 32'h1);
        chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        chk("bp_bus_addr", bus_addr, 32'h10);
        chk("bp_bus_wstrb", {28'h0, bus_wstrb}, 32'hF);
        chk("bp_bus_wdata", bus_wdata, 32'h11223344);
        @(posedge clk); #1;
      end
      bus_addr_ok = 1'b1;
      @(posedge clk); #1;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      @(posedge clk); #1;
      bus_data_ok = 1'b0;
      @(negedge clk);
      chk("bp_rsp", {31'h0, rsp_valid}, 32'h1);
      @(posedge clk); #1;
    end

    // flush in ADDR before addr_ok: bus_req drops, no response
    drive_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 5'd22);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("addr_flush_bus_req", {31'h0, bus_req}, 32'h0);
    chk("addr_flush_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // flush in DATA: data_ok still awaited, response dropped
    drive_req(1'b0, 2'd2, 1'b0, 32'h54, 32'h0, 5'd23);
    @(posedge clk); #1;
    req_valid = 1'b0; bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("data_flush_busy", {31'h0, req_ready}, 32'h0);
    bus_data_ok = 1'b1; bus_rdata = 32'hABCD0123;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("data_flush_ready", {31'h0, req_ready}, 32'h1);
    chk("data_flush_no_rsp", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // async reset while in DATA
    drive_req(1'b1, 2'd2, 1'b0, 32'h60, 32'h87654321, 5'd24);
    @(posedge clk); #1;
    req_valid = 1'b0; bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("arst_bus_addr", bus_addr, 32'h0);
    chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("arst_rsp_rd", {27'h0, rsp_rd}, 32'h0);
    chk("arst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;
    bus_data_ok = 1'b1;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("arst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    repeat (3) @(posedge clk);

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
